bsg_clk_gen_monitor_pdiv: RTL and testbench

Programmable clock-monitor divider that generates a low-frequency, duty-balanced observation clock from an on-chip generated clock. It is the parametrised successor to the fixed divide-by-30 monitor path. The divide ratio is runtime-programmable, updates are glitch-free, it has a clean enable/stop sequence, and it exposes a rising-edge counter for on-chip frequency checks. It sits between a clock generator output and the chip-level monitor pad, with all logic in the monitored clock domain.

---
 rtl/bsg_clk_gen_monitor_pdiv.sv | 127 ++++++++++++
 tb/tb_bsg_clk_gen_monitor_pdiv.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_clk_gen_monitor_pdiv.sv
// Programmable, glitch-free clock-monitor divider with enable/stop sequencing
// and a rising-edge counter, all in the monitored clock domain.
module bsg_clk_gen_monitor_pdiv #(
    parameter int width_p       = 16,
    parameter int default_div_p = 14,
    parameter int count_width_p = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     en_i,
    input  logic                     div_v_i,
    input  logic [width_p-1:0]       div_i,
    output logic                     div_ready_o,
    output logic                     clk_monitor_o,
    output logic                     running_o,
    output logic [count_width_p-1:0] edge_count_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    state_e                   state_r, state_n;
    logic [width_p-1:0]       div_r, div_n;
    logic [width_p-1:0]       pend_r;
    logic                     pend_v_r, pend_v_n;
    logic [width_p-1:0]       cnt_r, cnt_n;
    logic                     mon_r, mon_n;
    logic                     running_r;
    logic [count_width_p-1:0] edge_cnt_r;
    logic                     accept;
    logic                     boundary;

    assign accept   = div_v_i & ~pend_v_r;
    assign boundary = (cnt_r == div_r);

    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        mon_n    = mon_r;
        div_n    = div_r;
        pend_v_n = pend_v_r;

        unique case (state_r)
            IDLE: begin
                cnt_n = '0;
                mon_n = 1'b0;
                if (pend_v_r) begin
                    div_n    = pend_r;
                    pend_v_n = 1'b0;
                end
                if (en_i) state_n = RUN;
            end
            RUN: begin
                cnt_n = boundary ? '0 : cnt_r + 1'b1;
                if (boundary) begin
                    mon_n = ~mon_r;
                    if (pend_v_r) begin
                        div_n    = pend_r;
                        pend_v_n = 1'b0;
                    end
                end
                // A low half may be abandoned at once; a high half must finish.
                if (!en_i) begin
                    if (!mon_r) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        mon_n   = 1'b0;
                    end else if (boundary) begin
                        state_n = IDLE;
                    end else begin
                        state_n = STOPPING;
                    end
                end
            end
            STOPPING: begin
                cnt_n = boundary ? '0 : cnt_r + 1'b1;
                if (boundary) begin
                    mon_n   = 1'b0;
                    state_n = IDLE;
                    if (pend_v_r) begin
                        div_n    = pend_r;
                        pend_v_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                mon_n   = 1'b0;
            end
        endcase

        // Accept and apply are exclusive since accept needs pend_v_r low.
        if (accept) pend_v_n = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            mon_r      <= 1'b0;
            div_r      <= width_p'(default_div_p);
            pend_r     <= '0;
            pend_v_r   <= 1'b0;
            running_r  <= 1'b0;
            edge_cnt_r <= '0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            mon_r     <= mon_n;
            div_r     <= div_n;
            pend_v_r  <= pend_v_n;
            running_r <= (state_n != IDLE);
            if (accept) pend_r <= div_i;
            if (mon_n & ~mon_r) edge_cnt_r <= edge_cnt_r + 1'b1;
        end
    end

    assign div_ready_o   = ~pend_v_r;
    assign clk_monitor_o = mon_r;
    assign running_o     = running_r;
    assign edge_count_o  = edge_cnt_r;

endmodule

// File: tb/tb_bsg_clk_gen_monitor_pdiv.sv
// Randomized scoreboard bench for bsg_clk_gen_monitor_pdiv against a
// half-period countdown reference model; edge counter narrowed to 4 bits to hit wrap.
module tb_bsg_clk_gen_monitor_pdiv;

    localparam int WIDTH = 16;
    localparam int DEF_DIV = 14;
    localparam int CW = 4;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             en_i;
    logic             div_v_i;
    logic [WIDTH-1:0] div_i;
    logic             div_ready_o;
    logic             clk_monitor_o;
    logic             running_o;
    logic [CW-1:0]    edge_count_o;

    bsg_clk_gen_monitor_pdiv #(
        .width_p      (WIDTH),
        .default_div_p(DEF_DIV),
        .count_width_p(CW)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .en_i         (en_i),
        .div_v_i      (div_v_i),
        .div_i        (div_i),
        .div_ready_o  (div_ready_o),
        .clk_monitor_o(clk_monitor_o),
        .running_o    (running_o),
        .edge_count_o (edge_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          mon;
        logic          run;
        logic          rdy;
        logic [CW-1:0] ec;
    } exp_t;

    exp_t sb[$];
    int   n_compared = 0;
    int   n_mismatched = 0;

    // Reference model: a live half-period counts down from div+1 cycles.
    bit m_active, m_stopping, m_level, m_pend_valid;
    int m_div, m_pend, m_remaining, m_edges;

    task automatic modelStep(input bit rst, input bit en, input bit v, input int d);
        bit accept;
        bit last_cycle;
        if (rst) begin
            m_active = 0; m_stopping = 0; m_level = 0; m_pend_valid = 0;
            m_div = DEF_DIV; m_pend = 0; m_remaining = 0; m_edges = 0;
            return;
        end
        accept = v && !m_pend_valid;
        if (!m_active) begin
            m_level = 0;
            if (m_pend_valid) begin
                m_div = m_pend;
                m_pend_valid = 0;
            end
            if (en) begin
                m_active = 1;
                m_remaining = m_div + 1;
            end
        end else begin
            last_cycle = (m_remaining == 1);
            if (last_cycle) begin
                if (m_pend_valid) begin
                    m_div = m_pend;
                    m_pend_valid = 0;
                end
                m_remaining = m_div + 1;
            end else begin
                m_remaining = m_remaining - 1;
            end
            if (m_stopping) begin
                if (last_cycle) begin
                    m_level = 0; m_active = 0; m_stopping = 0;
                end
            end else if (!en) begin
                if (!m_level) m_active = 0;
                else if (last_cycle) begin
                    m_level = 0; m_active = 0;
                end else m_stopping = 1;
            end else if (last_cycle) begin
                m_level = !m_level;
                if (m_level) m_edges = (m_edges + 1) % (1 << CW);
            end
        end
        if (accept) begin
            m_pend = d;
            m_pend_valid = 1;
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input bit v, input int d);
        exp_t e;
        @(negedge clk_i);
        reset_i = rst;
        en_i    = en;
        div_v_i = v;
        div_i   = WIDTH'(d);
        modelStep(rst, en, v, d);
        e.mon = m_level;
        e.run = m_active;
        e.rdy = !m_pend_valid;
        e.ec  = CW'(m_edges);
        sb.push_back(e);
    endtask

    task automatic compareField(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        e = sb.pop_front();
        compareField("clk_monitor_o", int'(clk_monitor_o), int'(e.mon));
        compareField("running_o", int'(running_o), int'(e.run));
        compareField("div_ready_o", int'(div_ready_o), int'(e.rdy));
        compareField("edge_count_o", int'(edge_count_o), int'(e.ec));
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (sb.size() > 0) checkOutput();
        end
    end

    initial begin
        bit en_level;
        int d;
        reset_i = 1'b1;
        en_i    = 1'b0;
        div_v_i = 1'b0;
        div_i   = '0;

        repeat (3) applyStimulus(1, 0, 0, 0);
        // Default divide-by-30 run long enough for several periods.
        repeat (130) applyStimulus(0, 1, 0, 0);
        // Mid-half write of div 0, then a second write while still pending.
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 1, 5);
        repeat (40) applyStimulus(0, 1, 0, 0);
        // Reset in the middle of a run.
        applyStimulus(0, 1, 1, 9);
        repeat (25) applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        repeat (60) applyStimulus(0, 1, 0, 0);

        en_level = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) en_level = !en_level;
            if ($urandom_range(0, 9) == 0) d = 0;
            else d = $urandom_range(0, 12);
            applyStimulus(($urandom_range(0, 299) == 0),
                          en_level,
                          ($urandom_range(0, 14) == 0),
                          d);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_i);
        #2;
        if (sb.size() > 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
